ccta_sched: RTL and testbench

// - Round-robin scheduler sharing one combinational CCTA arithmetic unit between N requesters.
// - Each requester presents operands A/B/C (4b) and ctrl (1b) plus a req level.
// - The scheduler grants one requester, drives the operands to CCTA and holds them for SETTLE_CYC cycles.
// - It then captures CCTA's 5b q and returns it with the winning requester's index.
// - Sits between the operand producers and the single CCTA instance.

---
 rtl/ccta_sched.sv | 111 +++++++++++
 tb/tb_ccta_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccta_sched.sv
// Round-robin scheduler sharing one combinational CCTA unit between N_REQ requesters.
// Latency: res_valid pulses SETTLE_CYC edges after the gnt edge; issue interval SETTLE_CYC+1.
// Backpressure: requesters hold req until gnt; req is ignored while busy (SETTLE).
// Optional: define CCTA_SCHED_PRIO_EN for fixed priority (lowest index wins).
module ccta_sched #(
    parameter int N_REQ      = 4,
    parameter int SETTLE_CYC = 2,
    parameter int ID_W       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   op_a,
    input  logic [4*N_REQ-1:0]   op_b,
    input  logic [4*N_REQ-1:0]   op_c,
    input  logic [N_REQ-1:0]     op_ctrl,
    output logic [N_REQ-1:0]     gnt,
    output logic [3:0]           dp_a,
    output logic [3:0]           dp_b,
    output logic [3:0]           dp_c,
    output logic                 dp_ctrl,
    output logic                 dp_rst,
    input  logic [4:0]           dp_q,
    output logic                 res_valid,
    output logic [4:0]           res_q,
    output logic [ID_W-1:0]      res_id,
    output logic                 busy
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_r;
    logic [ID_W-1:0]   win;
    logic [CNT_W-1:0]  cnt;

    // Winner select: scanning downward so the last hit is the first in search order.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx = '0;
        win = '0;
`ifdef CCTA_SCHED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ID_W'(i);
            if (req[idx]) win = idx;
        end
`else
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (req[idx]) win = idx;
        end
`endif
    end

    // Two-state FSM: IDLE grants and launches, SETTLE holds operands then captures q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= ID_W'(N_REQ - 1);
            id_r      <= '0;
            cnt       <= '0;
            gnt       <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_c      <= '0;
            dp_ctrl   <= 1'b0;
            dp_rst    <= 1'b1;
            res_valid <= 1'b0;
            res_q     <= '0;
            res_id    <= '0;
            busy      <= 1'b0;
        end else begin
            gnt       <= '0;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt[win] <= 1'b1;
                        dp_a     <= op_a[{win, 2'b00} +: 4];
                        dp_b     <= op_b[{win, 2'b00} +: 4];
                        dp_c     <= op_c[{win, 2'b00} +: 4];
                        dp_ctrl  <= op_ctrl[win];
                        dp_rst   <= 1'b0;
                        cnt      <= CNT_W'(SETTLE_CYC);
                        rr_ptr   <= win;
                        id_r     <= win;
                        busy     <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_W'(1)) begin
                        res_q     <= dp_q;
                        res_id    <= id_r;
                        res_valid <= 1'b1;
                        dp_rst    <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccta_sched.sv
// Scoreboard bench for ccta_sched: stimulus pushes expected grants/results, monitor pops and compares.
// The CCTA stand-in returns a+b+c (ctrl=0) or a^b^c (ctrl=1), and 0 while dp_rst is high.
module tb_ccta_sched;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [4*N-1:0]  op_a = '0, op_b = '0, op_c = '0;
    logic [N-1:0]    op_ctrl = '0;
    logic [N-1:0]    gnt;
    logic [3:0]      dp_a, dp_b, dp_c;
    logic            dp_ctrl, dp_rst;
    logic [4:0]      dp_q;
    logic            res_valid;
    logic [4:0]      res_q;
    logic [IW-1:0]   res_id;
    logic            busy;

    int ncmp = 0;
    int nbad = 0;
    int cyc  = 0;
    int last_gnt_cyc = 0;

    int          exp_gnt[$];
    logic [6:0]  exp_res[$];

    ccta_sched #(.N_REQ(N), .SETTLE_CYC(S), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .req(req),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_ctrl(op_ctrl),
        .gnt(gnt), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
        .dp_ctrl(dp_ctrl), .dp_rst(dp_rst), .dp_q(dp_q),
        .res_valid(res_valid), .res_q(res_q), .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] ccta(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic ctl);
        return ctl ? {1'b0, a ^ b ^ c} : ({1'b0, a} + {1'b0, b} + {1'b0, c});
    endfunction

    assign dp_q = dp_rst ? 5'd0 : ccta(dp_a, dp_b, dp_c, dp_ctrl);

    task automatic check(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic ctl);
        op_a[4*i +: 4] = a;
        op_b[4*i +: 4] = b;
        op_c[4*i +: 4] = c;
        op_ctrl[i]     = ctl;
    endtask

    task automatic expect_op(input int i, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic ctl);
        logic [1:0] id;
        id = 2'(i);
        exp_gnt.push_back(i);
        exp_res.push_back({id, ccta(a, b, c, ctl)});
    endtask

    task automatic wait_gnt(input int i);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!gnt[i] && k < 20);
        if (!gnt[i]) check("gnt_timeout", int'(gnt[i]), 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compares every grant and every result against the scoreboard queues.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (gnt != '0) begin
                    if (exp_gnt.size() == 0) check("gnt_unexpected", int'(gnt), 0);
                    else check("gnt", int'(gnt), 1 << exp_gnt.pop_front());
                    last_gnt_cyc = cyc;
                end
                if (res_valid) begin
                    if (exp_res.size() == 0) begin
                        check("res_unexpected", int'(res_valid), 0);
                    end else begin
                        e = exp_res.pop_front();
                        check("res_q", int'(res_q), int'(e[4:0]));
                        check("res_id", int'(res_id), int'(e[6:5]));
                        check("latency", cyc - last_gnt_cyc, S);
                    end
                end
            end
        end
    end

    initial begin
        int prev;
        int id;

        // Reset values while rst is held low.
        repeat (2) @(negedge clk);
        check("rst_dp_rst", int'(dp_rst), 1);
        check("rst_gnt", int'(gnt), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_q", int'(res_q), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;

        // Single request from requester 0.
        set_op(0, 4'h4, 4'h1, 4'h9, 1'b0);
        expect_op(0, 4'h4, 4'h1, 4'h9, 1'b0);
        req = 4'b0001;
        wait_gnt(0);
        req[0] = 1'b0;
        check("single_dp_a", int'(dp_a), 4);
        check("single_dp_b", int'(dp_b), 1);
        check("single_dp_c", int'(dp_c), 9);
        check("single_busy", int'(busy), 1);
        check("single_dp_rst", int'(dp_rst), 0);
        set_op(0, 4'hf, 4'hf, 4'hf, 1'b1);
        repeat (4) @(negedge clk);
        check("single_res_q_held", int'(res_q), 14);

        // Round-robin with all four requesting continuously.
        do_reset();
        set_op(0, 4'h4, 4'h1, 4'h9, 1'b0);
        set_op(1, 4'h7, 4'h8, 4'h2, 1'b1);
        set_op(2, 4'hf, 4'hf, 4'h1, 1'b0);
        set_op(3, 4'h0, 4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
`ifdef CCTA_SCHED_PRIO_EN
            id = 0;
`else
            id = k % N;
`endif
            expect_op(id, op_a[4*id +: 4], op_b[4*id +: 4], op_c[4*id +: 4], op_ctrl[id]);
        end
        req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
`ifdef CCTA_SCHED_PRIO_EN
            wait_gnt(0);
`else
            wait_gnt(k % N);
`endif
            if (k > 0) check("rr_interval", cyc - prev, S + 1);
            prev = cyc;
        end
        req = '0;
        repeat (5) @(negedge clk);
        check("rr_drain_res", exp_res.size(), 0);
        check("rr_drain_gnt", exp_gnt.size(), 0);

        // Mid-op request: sole requester 0 re-granted, req1 skipped, req2 granted after result.
        set_op(0, 4'h3, 4'h5, 4'h6, 1'b1);
        expect_op(0, 4'h3, 4'h5, 4'h6, 1'b1);
        req = 4'b0001;
        wait_gnt(0);
        req[0] = 1'b0;
        set_op(2, 4'ha, 4'h2, 4'h3, 1'b0);
        expect_op(2, 4'ha, 4'h2, 4'h3, 1'b0);
        req[2] = 1'b1;
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        check("midop_no_gnt_settle", int'(gnt), 0);
        check("midop_dp_rst_low", int'(dp_rst), 0);
        @(negedge clk);
        check("midop_res_valid", int'(res_valid), 1);
        check("midop_no_gnt_resv", int'(gnt), 0);
        check("midop_dp_rst_high", int'(dp_rst), 1);
        @(negedge clk);
        check("midop_gnt2", int'(gnt), 4);
        req[2] = 1'b0;
        repeat (4) @(negedge clk);

        // Reset abort in the first SETTLE cycle.
        set_op(1, 4'h1, 4'h1, 4'h1, 1'b0);
        exp_gnt.push_back(1);
        req = 4'b0010;
        wait_gnt(1);
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_dp_rst", int'(dp_rst), 1);
        check("abort_dp_a", int'(dp_a), 0);
        check("abort_res_valid", int'(res_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        set_op(0, 4'h2, 4'h2, 4'h2, 1'b0);
        set_op(1, 4'h9, 4'h9, 4'h9, 1'b0);
        expect_op(0, 4'h2, 4'h2, 4'h2, 1'b0);
        req = 4'b0011;
        wait_gnt(0);
        req = '0;
        repeat (5) @(negedge clk);
        check("final_drain_res", exp_res.size(), 0);
        check("final_drain_gnt", exp_gnt.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
